sdram_rdret_32b: RTL and testbench
==================================

// Module: sdram_rdret_32b
// PURPOSE
// Read-return path of the 32-bit SDRAM controller, the read-direction counterpart of the write data path.
// Captures sdram_dq_i and tracks each READ command through the CAS latency.
// Steers every returned beat to the requesting bank port (#0-3) with valid, first, last and truncation strobes.
// Sits between the SDRAM pads and the per-bank read clients, driven by the same command sequencer.
// PARAMETERS
// CAS_LAT    2  SDRAM CAS latency in clk cycles (legal 2..3)
// BURST_LEN  4  beats per READ burst (legal 1,2,4,8)
// CAP_DLY    1  register stages on sdram_dq_i before rd_data (legal 1..2)
// PORTS
// clk         in   1   master clock (72 MHz); the only clock
// rst         in   1   asynchronous reset, active-high
// rd_issue    in   4   one-hot: READ command for bank n presented to SDRAM this cycle
// sdram_dq_i  in   32  SDRAM data input from pads
// rd_data     out  32  returned read data; shared by all banks, qualified by rd_valid
// rd_valid    out  4   one-hot: rd_data is a beat for bank n
// rd_first    out  1   current beat is beat 0 of its burst
// rd_last     out  1   current beat is beat BURST_LEN-1 of its burst
// rd_trunc    out  1   current burst start cut short an unfinished previous burst
// rd_busy     out  1   any READ pending in the tag pipe or burst in progress
// rd_err      out  1   pulse: rd_issue was multi-hot
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, rd_data 0, capture stages 0, tag pipe 0, burst counter 0.
// - Reset mid-burst drops all pending and in-flight reads. No beats are issued after release.
// - Timing: issue at cycle 0. Beat k sits on sdram_dq_i in cycle CAS_LAT+k. It shows on rd_data in cycle CAS_LAT+CAP_DLY+k.
// - rd_valid is aligned with rd_data. No handshake; clients must accept every beat.
// - Tag pipe: a shift register of depth D=CAS_LAT+CAP_DLY-1, 4 bits per stage.
//   - Stage 0 <= sanitized rd_issue.
//   - The output of the last stage starts a burst in the next cycle.
// - Sanitize: a multi-hot rd_issue keeps only its lowest set bit. rd_err is high in cycle 1 and is registered.
// - Burst FSM, states IDLE and BURST:
//   - A tag emerges in IDLE: go to BURST, bank_r<=tag, beat_cnt<=0.
//   - In BURST: rd_valid=bank_r, beat_cnt++ per cycle.
//   - beat_cnt==BURST_LEN-1 and no new tag: rd_last=1, then go to IDLE.
//   - beat_cnt==BURST_LEN-1 and a new tag emerges in the same cycle: stay in BURST and restart (seamless). rd_trunc=0.
//   - A new tag emerges while beat_cnt<BURST_LEN-1: this is a READ interrupt. Restart the counter with the new bank.
//     The new first beat carries rd_first=1 and rd_trunc=1. The old burst never gives rd_last.
// - rd_first=1 exactly when beat_cnt==0 and in BURST. With BURST_LEN=1, rd_first and rd_last are both 1 on the single beat.
// - rd_valid, rd_first, rd_last, rd_trunc and rd_err are all registered (no comb path from inputs).
// - rd_busy = |tag_pipe | (state==BURST).
// - beat_cnt is 3 bits wide and resets to 0; it never wraps past BURST_LEN-1.
// - A zero rd_issue adds an empty tag and has no effect.
// TESTING
// - CL2/BL4/CAP1, rd_issue=0001 @c0, dq=A0..A3 @c2..c5 -> rd_valid=0001 c3..c6; rd_data=A0..A3; rd_first c3, rd_last c6.
// - rd_issue=0010 @c0, 0100 @c4 -> bank1 c3..c6, bank2 c7..c10. rd_valid never 0 between them, rd_trunc=0, rd_last c6 and c10.
// - rd_issue=0001 @c0, 1000 @c2 -> bank0 beats c3,c4 only. Bank3 c5..c8 with rd_first=rd_trunc=1 @c5. No rd_last @c4.
// - rd_issue=0110 @c0 -> rd_err=1 @c1 only; bank1 gets 4 beats c3..c6, bank2 gets none.
// - rst pulse @c4 during the c3..c6 burst -> all outputs 0 immediately; rd_valid stays 0 after release, rd_busy=0.
// - CL3/BL8/CAP2, rd_issue=0100 @c0 -> rd_valid=0100 c5..c12, rd_first c5, rd_last c12; rd_busy 1 c1..c12.

Source files
------------

// File: rtl/sdram_rdret_32b_if.sv
// Read-return bus of the 32-bit SDRAM controller: the READ command strobe and
// pad data going in, steered beats and status coming out.
interface sdram_rdret_32b_if;
    logic [3:0]  rd_issue;
    logic [31:0] sdram_dq_i;
    logic [31:0] rd_data;
    logic [3:0]  rd_valid;
    logic        rd_first;
    logic        rd_last;
    logic        rd_trunc;
    logic        rd_busy;
    logic        rd_err;

    // Sequencer / pad side
    modport master (
        output rd_issue, sdram_dq_i,
        input  rd_data, rd_valid, rd_first, rd_last, rd_trunc, rd_busy, rd_err
    );

    // Read-return block side
    modport slave (
        input  rd_issue, sdram_dq_i,
        output rd_data, rd_valid, rd_first, rd_last, rd_trunc, rd_busy, rd_err
    );
endinterface

// File: rtl/sdram_rdret_32b.sv
// Read-return path of the 32-bit SDRAM controller. Each READ is tagged with
// its bank and delayed through a tag pipe so that the tag emerges exactly one
// cycle before the first beat leaves the capture registers. A small burst FSM
// then steers BURST_LEN beats to that bank, handling seamless back-to-back
// bursts and READ interrupts.
module sdram_rdret_32b #(
    parameter int CAS_LAT   = 2,
    parameter int BURST_LEN = 4,
    parameter int CAP_DLY   = 1
) (
    input  logic             clk,
    input  logic             rst,
    sdram_rdret_32b_if.slave bus
);
    // Tag pipe depth: tag reaches the last stage one cycle before its beat 0
    // shows on rd_data, so the FSM can register rd_valid in step with data.
    localparam int         D         = CAS_LAT + CAP_DLY - 1;
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [3:0]                 issue_clean;
    logic                       issue_multi;
    logic [D-1:0][3:0]          tag_pipe;
    logic [CAP_DLY-1:0][31:0]   cap;
    logic [3:0]                 tag_out;
    logic                       tag_hit;
    logic [0:0]                 state;
    logic [3:0]                 bank_r;
    logic [2:0]                 beat_cnt;
    logic                       trunc_r;
    logic                       err_r;

    // Keep only the lowest requested bank; anything more is a sequencer fault.
    assign issue_clean = bus.rd_issue & (~bus.rd_issue + 4'd1);
    assign issue_multi = |(bus.rd_issue & (bus.rd_issue - 4'd1));

    assign tag_out = tag_pipe[D-1];
    assign tag_hit = |tag_out;

    // Tag pipe: one bank tag per cycle, empty tags for idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= issue_clean;
            for (int i = 1; i < D; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Pad capture stages; the last stage is rd_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap <= '0;
        end else begin
            cap[0] <= bus.sdram_dq_i;
            for (int i = 1; i < CAP_DLY; i++) cap[i] <= cap[i-1];
        end
    end

    // Multi-hot error strobe, one cycle after the offending issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_r <= 1'b0;
        else     err_r <= issue_multi;
    end

    // Burst FSM: a new tag always restarts the counter; it counts as a
    // truncation only if the current burst had not reached its last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bank_r   <= 4'd0;
            beat_cnt <= 3'd0;
            trunc_r  <= 1'b0;
        end else begin
            trunc_r <= 1'b0;
            if (tag_hit) begin
                state    <= S_BURST;
                bank_r   <= tag_out;
                beat_cnt <= 3'd0;
                trunc_r  <= (state == S_BURST) && (beat_cnt != LAST_BEAT);
            end else if (state == S_BURST) begin
                if (beat_cnt == LAST_BEAT) begin
                    state    <= S_IDLE;
                    beat_cnt <= 3'd0;
                end else begin
                    beat_cnt <= beat_cnt + 3'd1;
                end
            end
        end
    end

    assign bus.rd_data  = cap[CAP_DLY-1];
    assign bus.rd_valid = (state == S_BURST) ? bank_r : 4'd0;
    assign bus.rd_first = (state == S_BURST) && (beat_cnt == 3'd0);
    assign bus.rd_last  = (state == S_BURST) && (beat_cnt == LAST_BEAT);
    assign bus.rd_trunc = trunc_r;
    assign bus.rd_busy  = (|tag_pipe) || (state == S_BURST);
    assign bus.rd_err   = err_r;
endmodule

// File: tb/tb_sdram_rdret_32b.sv
// Scoreboard bench for sdram_rdret_32b: DUT A at CL2/BL4/CAP1, DUT B at
// CL3/BL8/CAP2. Expected beats are queued when a READ is issued and checked
// against each returned beat, including its cycle of arrival.
module tb_sdram_rdret_32b;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   c0;

    typedef struct {
        int          cyc;
        logic [3:0]  bank;
        logic [31:0] data;
        logic        first;
        logic        last;
        logic        trunc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    sdram_rdret_32b_if ifa ();
    sdram_rdret_32b_if ifb ();

    sdram_rdret_32b #(.CAS_LAT(2), .BURST_LEN(4), .CAP_DLY(1)) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    sdram_rdret_32b #(.CAS_LAT(3), .BURST_LEN(8), .CAP_DLY(2)) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dq_of(input int c);
        return 32'hC0DE_0000 + 32'(c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        ifa.sdram_dq_i = dq_of(cyc);
        ifb.sdram_dq_i = dq_of(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Queue nb beats of a burst whose beat 0 leaves rd_data in cycle s.
    task automatic push_burst(input int sel, input logic [3:0] bank, input int s,
                              input int nb, input int bl, input int cap, input logic tr);
        exp_t e;
        for (int k = 0; k < nb; k++) begin
            e.cyc   = s + k;
            e.bank  = bank;
            e.data  = dq_of(s + k - cap);
            e.first = (k == 0);
            e.last  = (k == bl - 1);
            e.trunc = (k == 0) && tr;
            if (sel == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
    endtask

    // Scoreboard for DUT A
    always @(negedge clk) begin
        if (rst) begin
            chk("a_valid_rst", 64'(ifa.rd_valid), 64'd0);
        end else if (ifa.rd_valid != 4'd0) begin
            if (qa.size() == 0) begin
                chk("a_spurious", 64'(ifa.rd_valid), 64'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_cyc", 64'(cyc), 64'(ea.cyc));
                chk("a_ctl", 64'({ifa.rd_valid, ifa.rd_first, ifa.rd_last, ifa.rd_trunc}),
                    64'({ea.bank, ea.first, ea.last, ea.trunc}));
                chk("a_data", 64'(ifa.rd_data), 64'(ea.data));
            end
        end else begin
            chk("a_idle_ctl", 64'({ifa.rd_first, ifa.rd_last, ifa.rd_trunc}), 64'd0);
            if (qa.size() != 0 && qa[0].cyc <= cyc) begin
                chk("a_missing", 64'(ifa.rd_valid), 64'(qa[0].bank));
                void'(qa.pop_front());
            end
        end
    end

    // Scoreboard for DUT B
    always @(negedge clk) begin
        if (rst) begin
            chk("b_valid_rst", 64'(ifb.rd_valid), 64'd0);
        end else if (ifb.rd_valid != 4'd0) begin
            if (qb.size() == 0) begin
                chk("b_spurious", 64'(ifb.rd_valid), 64'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_cyc", 64'(cyc), 64'(eb.cyc));
                chk("b_ctl", 64'({ifb.rd_valid, ifb.rd_first, ifb.rd_last, ifb.rd_trunc}),
                    64'({eb.bank, eb.first, eb.last, eb.trunc}));
                chk("b_data", 64'(ifb.rd_data), 64'(eb.data));
            end
        end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
            chk("b_missing", 64'(ifb.rd_valid), 64'(qb[0].bank));
            void'(qb.pop_front());
        end
    end

    initial begin
        rst = 1'b1;
        ifa.rd_issue = 4'd0;
        ifb.rd_issue = 4'd0;
        ifa.sdram_dq_i = dq_of(0);
        ifb.sdram_dq_i = dq_of(0);

        // Reset state
        idle(2);
        @(negedge clk);
        chk("rst_data_a", 64'(ifa.rd_data), 64'd0);
        chk("rst_flags_a", 64'({ifa.rd_first, ifa.rd_last, ifa.rd_trunc, ifa.rd_busy, ifa.rd_err}), 64'd0);
        chk("rst_data_b", 64'(ifb.rd_data), 64'd0);
        chk("rst_flags_b", 64'({ifb.rd_first, ifb.rd_last, ifb.rd_trunc, ifb.rd_busy, ifb.rd_err}), 64'd0);
        tick();
        rst = 1'b0;
        idle(3);

        // Single burst, bank 0
        tick(); c0 = cyc;
        ifa.rd_issue = 4'b0001;
        push_burst(0, 4'b0001, c0 + 3, 4, 4, 1, 1'b0);
        tick();
        ifa.rd_issue = 4'b0000;
        @(negedge clk);
        chk("busy_c1", 64'(ifa.rd_busy), 64'd1);
        idle(8);
        @(negedge clk);
        chk("busy_idle", 64'(ifa.rd_busy), 64'd0);

        // Seamless back-to-back: bank 1 then bank 2
        tick(); c0 = cyc;
        ifa.rd_issue = 4'b0010;
        push_burst(0, 4'b0010, c0 + 3, 4, 4, 1, 1'b0);
        tick();
        ifa.rd_issue = 4'b0000;
        idle(2);
        tick();
        ifa.rd_issue = 4'b0100;
        push_burst(0, 4'b0100, c0 + 7, 4, 4, 1, 1'b0);
        tick();
        ifa.rd_issue = 4'b0000;
        idle(10);

        // READ interrupt: bank 0 cut after two beats by bank 3
        tick(); c0 = cyc;
        ifa.rd_issue = 4'b0001;
        push_burst(0, 4'b0001, c0 + 3, 2, 4, 1, 1'b0);
        tick();
        ifa.rd_issue = 4'b0000;
        tick();
        ifa.rd_issue = 4'b1000;
        push_burst(0, 4'b1000, c0 + 5, 4, 4, 1, 1'b1);
        tick();
        ifa.rd_issue = 4'b0000;
        idle(10);

        // Multi-hot issue: lowest bank wins, error pulse one cycle later
        tick(); c0 = cyc;
        ifa.rd_issue = 4'b0110;
        push_burst(0, 4'b0010, c0 + 3, 4, 4, 1, 1'b0);
        @(negedge clk);
        chk("err_c0", 64'(ifa.rd_err), 64'd0);
        tick();
        ifa.rd_issue = 4'b0000;
        @(negedge clk);
        chk("err_c1", 64'(ifa.rd_err), 64'd1);
        tick();
        @(negedge clk);
        chk("err_c2", 64'(ifa.rd_err), 64'd0);
        idle(10);

        // Reset mid-burst drops the remaining beats
        tick(); c0 = cyc;
        ifa.rd_issue = 4'b0001;
        push_burst(0, 4'b0001, c0 + 3, 1, 4, 1, 1'b0);
        tick();
        ifa.rd_issue = 4'b0000;
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_flags", 64'({ifa.rd_first, ifa.rd_last, ifa.rd_trunc, ifa.rd_busy, ifa.rd_err}), 64'd0);
        chk("rst_mid_data", 64'(ifa.rd_data), 64'd0);
        idle(2);
        rst = 1'b0;
        idle(8);
        @(negedge clk);
        chk("rst_mid_busy", 64'(ifa.rd_busy), 64'd0);

        // CL3/BL8/CAP2 burst on bank 2
        tick(); c0 = cyc;
        ifb.rd_issue = 4'b0100;
        push_burst(1, 4'b0100, c0 + 5, 8, 8, 2, 1'b0);
        @(negedge clk);
        chk("busy_b_c0", 64'(ifb.rd_busy), 64'd0);
        tick();
        ifb.rd_issue = 4'b0000;
        @(negedge clk);
        chk("busy_b_c1", 64'(ifb.rd_busy), 64'd1);
        for (int k = 2; k <= 13; k++) begin
            tick();
            @(negedge clk);
            chk("busy_b", 64'(ifb.rd_busy), (k <= 12) ? 64'd1 : 64'd0);
        end

        idle(5);
        chk("qa_empty", 64'(qa.size()), 64'd0);
        chk("qb_empty", 64'(qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
